// File: rtl/gray_pkg.sv
// Shared Gray-code constants and width-agnostic conversion helpers.
// Helpers operate on a fixed 32-bit container; bits above `w` are masked off.
package gray_pkg;

   localparam int unsigned GRAY_W_DEFAULT = 4;
   localparam int unsigned GRAY_W_MAX     = 32;

   function automatic logic [GRAY_W_MAX-1:0] width_mask(input int unsigned w);
      if (w >= GRAY_W_MAX) return '1;
      return (32'(1) << w) - 32'(1);
   endfunction

   function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b,
                                                       input int unsigned w);
      logic [GRAY_W_MAX-1:0] bm;
      bm = b & width_mask(w);
      return bm ^ (bm >> 1);
   endfunction

   function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g,
                                                       input int unsigned w);
      logic [GRAY_W_MAX-1:0] gm;
      logic [GRAY_W_MAX-1:0] b;
      logic                  acc;
      gm  = g & width_mask(w);
      b   = '0;
      acc = 1'b0;
      for (int i = GRAY_W_MAX - 1; i >= 0; i--) begin
         acc  = acc ^ gm[i];
         b[i] = acc;
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational WIDTH-bit reflected-Gray to binary converter (prefix XOR from the MSB).
module gray_to_bin
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o_c
);

   always_comb begin : conv
      logic acc;
      acc     = 1'b0;
      bin_o_c = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         acc        = acc ^ gray_i[i];
         bin_o_c[i] = acc;
      end
   end

endmodule

// File: rtl/gray_counter.sv
// Free-running up/down Gray-code counter with registered binary mirror and wrap pulse.
module gray_counter
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] BIN_MAX  = '1;
   localparam logic [WIDTH-1:0] BIN_ZERO = '0;
   localparam logic [WIDTH-1:0] BIN_ONE  = WIDTH'(1);

   logic             sync_q;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] bin_cur_c, bin_nxt_c;
   logic             step_c;

   // Reset release: this flop is the first stage, the state registers act as the second,
   // so the first advance lands on the second rising edge after rst_n rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 1'b0;
      else        sync_q <= 1'b1;
   end

   gray_to_bin #(.WIDTH(WIDTH)) u_g2b (
      .gray_i  (gray_q),
      .bin_o_c (bin_cur_c)
   );

   // Next state: decode, +/-1 modulo 2^WIDTH, re-encode; wrap flags the boundary step.
   always_comb begin
      gray_d    = gray_q;
      bin_d     = bin_q;
      wrap_d    = 1'b0;
      step_c    = sync_q & en;
      bin_nxt_c = up_dn ? (bin_cur_c + BIN_ONE) : (bin_cur_c - BIN_ONE);
      if (step_c) begin
         gray_d = WIDTH'(bin2gray(32'(bin_nxt_c), WIDTH));
         bin_d  = bin_nxt_c;
         wrap_d = up_dn ? (bin_cur_c == BIN_MAX) : (bin_cur_c == BIN_ZERO);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gray_q <= '0;
         bin_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         gray_q <= gray_d;
         bin_q  <= bin_d;
         wrap_q <= wrap_d;
      end
   end

   assign gray_out = gray_q;
   assign bin_out  = bin_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Randomized bench for gray_counter (WIDTH=4 and WIDTH=8) against a sequence-index model.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en4 = 1'b0, up4 = 1'b1, en8 = 1'b0, up8 = 1'b1;
   logic [3:0] gray4, bin4;
   logic [7:0] gray8, bin8;
   logic       wrap4, wrap8;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: position in the published Gray sequence, plus edges since release.
   logic [3:0] gseq4 [0:15] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
   int m4 = 0, m8 = 0, rel = 0, w4_seen = 0;
   logic mw4 = 1'b0, mw8 = 1'b0;

   always #5 clk = ~clk;

   gray_counter #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .up_dn(up4),
      .gray_out(gray4), .bin_out(bin4), .wrap(wrap4)
   );

   gray_counter #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .up_dn(up8),
      .gray_out(gray8), .bin_out(bin8), .wrap(wrap8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m4 = 0; m8 = 0; rel = 0; mw4 = 1'b0; mw8 = 1'b0;
   endtask

   // One clock: drive on the falling edge, advance the model at the rising edge, check 1 ns later.
   task automatic step(input logic r, input logic e4, input logic d4,
                       input logic e8, input logic d8);
      logic [3:0] prev4;
      logic [7:0] prev8;
      logic       adv4, adv8;
      @(negedge clk);
      rst_n = r; en4 = e4; up4 = d4; en8 = e8; up8 = d8;
      @(posedge clk);
      prev4 = gseq4[m4];
      prev8 = 8'(gray_of(m8));
      adv4  = 1'b0;
      adv8  = 1'b0;
      if (!rst_n) begin
         model_reset();
      end else begin
         rel++;
         adv4 = (rel >= 2) && e4;
         adv8 = (rel >= 2) && e8;
         mw4  = adv4 && (d4 ? (m4 == 15) : (m4 == 0));
         mw8  = adv8 && (d8 ? (m8 == 255) : (m8 == 0));
         if (adv4) m4 = d4 ? (m4 + 1) % 16 : (m4 + 15) % 16;
         if (adv8) m8 = d8 ? (m8 + 1) % 256 : (m8 + 255) % 256;
      end
      #1;
      check("gray4", 32'(gray4), 32'(gseq4[m4]));
      check("bin4",  32'(bin4),  32'(m4));
      check("wrap4", 32'(wrap4), 32'(mw4));
      check("gray8", 32'(gray8), 32'(gray_of(m8)));
      check("bin8",  32'(bin8),  32'(m8));
      check("wrap8", 32'(wrap8), 32'(mw8));
      if (adv4) check("onebit4", 32'($countones(gray4 ^ prev4)), 32'd1);
      if (adv8) check("onebit8", 32'($countones(gray8 ^ prev8)), 32'd1);
      if (wrap4) w4_seen++;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_g4"}, 32'(gray4), 32'd0);
      check({tag, "_b4"}, 32'(bin4),  32'd0);
      check({tag, "_w4"}, 32'(wrap4), 32'd0);
      check({tag, "_g8"}, 32'(gray8), 32'd0);
      check({tag, "_b8"}, 32'(bin8),  32'd0);
      check({tag, "_w8"}, 32'(wrap8), 32'd0);
   endtask

   initial begin
      logic re4, rd4, re8, rd8;

      // Reset held with clock running, then release and count up 35 cycles.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_zero("rst_hold");
      for (int i = 0; i < 35; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

      // Asynchronous reset mid-count: outputs clear without a clock edge.
      #2 rst_n = 1'b0;
      #1 check_zero("rst_async");
      model_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

      // Random enable/direction on both instances.
      for (int i = 0; i < 300; i++) begin
         re4 = ($urandom_range(0, 3) != 0);
         rd4 = 1'($urandom_range(0, 1));
         re8 = ($urandom_range(0, 3) != 0);
         rd8 = 1'($urandom_range(0, 1));
         step(1'b1, re4, rd4, re8, rd8);
      end

      // Down count from 0: 16 advances, exactly one wrap (0 -> 8).
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      w4_seen = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("down_first", 32'(gray4), 32'h8);
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("down_wraps", 32'(w4_seen), 32'd1);

      // Enable gating at gray 6, then reversal at gray D.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20 && m4 != 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("gate_at6", 32'(gray4), 32'h6);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      check("gate_hold_g", 32'(gray4), 32'h6);
      check("gate_hold_b", 32'(bin4),  32'd4);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("gate_resume", 32'(gray4), 32'h7);
      for (int i = 0; i < 20 && m4 != 9; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      check("rev_atD", 32'(gray4), 32'hD);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rev_g", 32'(gray4), 32'hC);
      check("rev_b", 32'(bin4),  32'd8);

      // WIDTH=8 full pass up through 0x80 -> 0x00.
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 255; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("w8_at80", 32'(gray8), 32'h80);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("w8_wrap_g", 32'(gray8), 32'h00);
      check("w8_wrap_p", 32'(wrap8), 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("w8_wrap_1cyc", 32'(wrap8), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
